// File: rtl/md_unit.sv
// Multiply/divide unit beside the EX-stage ALU: owns HI/LO and models multi-cycle
// mult/div latency with a busy flag so the hazard unit can stall md instructions.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDsel,
    input  logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [31:0]   r_hi_n;
    logic [31:0]   r_lo_n;
    logic          r_div0;

    logic          w_is_mult;
    logic          w_is_div;
    logic          w_signed;
    logic          w_go;
    logic [63:0]   w_ext_a;
    logic [63:0]   w_ext_b;
    logic [63:0]   w_prod;
    logic          w_neg_a;
    logic          w_neg_b;
    logic [31:0]   w_mag_a;
    logic [31:0]   w_mag_b;
    logic [31:0]   w_div_b;
    logic [31:0]   w_q_mag;
    logic [31:0]   w_r_mag;
    logic [31:0]   w_quot;
    logic [31:0]   w_rem;

    assign w_is_mult = (MDsel == 4'd1) || (MDsel == 4'd2);
    assign w_is_div  = (MDsel == 4'd3) || (MDsel == 4'd4);
    assign w_signed  = (MDsel == 4'd1) || (MDsel == 4'd3);
    assign w_go      = start && !r_busy && (w_is_mult || w_is_div);

    // Sign- or zero-extend to 64 bits so one multiplier serves mult and multu.
    assign w_ext_a = w_signed ? {{32{A[31]}}, A} : {32'd0, A};
    assign w_ext_b = w_signed ? {{32{B[31]}}, B} : {32'd0, B};
    assign w_prod  = w_ext_a * w_ext_b;

    // Signed divide runs on magnitudes; this also yields 0x80000000 / -1 = 0x80000000
    // without relying on the host's signed-overflow behaviour.
    assign w_neg_a = w_signed & A[31];
    assign w_neg_b = w_signed & B[31];
    assign w_mag_a = w_neg_a ? (~A + 32'd1) : A;
    assign w_mag_b = w_neg_b ? (~B + 32'd1) : B;
    assign w_div_b = (B == 32'd0) ? 32'd1 : w_mag_b;
    assign w_q_mag = w_mag_a / w_div_b;
    assign w_r_mag = w_mag_a % w_div_b;
    assign w_quot  = (w_neg_a ^ w_neg_b) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem   = w_neg_a ? (~w_r_mag + 32'd1) : w_r_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_hi_n <= 32'd0;
            r_lo_n <= 32'd0;
            r_div0 <= 1'b0;
        end else if (r_busy) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
                if (!r_div0) begin
                    r_hi <= r_hi_n;
                    r_lo <= r_lo_n;
                end
            end
        end else if (w_go) begin
            r_hi_n <= w_is_mult ? w_prod[63:32] : w_rem;
            r_lo_n <= w_is_mult ? w_prod[31:0]  : w_quot;
            r_div0 <= w_is_div && (B == 32'd0);
            r_cnt  <= w_is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            r_busy <= 1'b1;
        end else if (MDsel == 4'd5) begin
            r_hi <= A;
        end else if (MDsel == 4'd6) begin
            r_lo <= A;
        end
    end

    always_comb begin
        out = 32'd0;
        if (MDsel == 4'd7)
            out = r_hi;
        else if (MDsel == 4'd8)
            out = r_lo;
    end

    assign busy  = r_busy;
    assign stall = r_busy | start;
    assign HI    = r_hi;
    assign LO    = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, arithmetic corner cases, mthi/mtlo/mfhi/mflo,
// ignored requests while busy, and reset in the middle of a divide.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDsel;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] out;

    int tests_run = 0;
    int tests_failed = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .MDsel (MDsel),
        .start (start),
        .busy  (busy),
        .stall (stall),
        .HI    (HI),
        .LO    (LO),
        .out   (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one mult/div for a single cycle, then count busy cycles (bounded).
    task automatic run_op(input string tag, input logic [3:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input int exp_n, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit toggle);
        int n = 0;
        int stall_low = 0;
        A = a; B = b; MDsel = sel; start = 1'b1;
        #1;
        check({tag, "_stall_start"}, {31'd0, stall}, 32'd1);
        tick();
        start = 1'b0; MDsel = 4'd0;
        while (busy && n < 100) begin
            if (toggle) begin
                A = $urandom; B = $urandom;
                #1;
            end
            if (!stall) stall_low++;
            n++;
            tick();
        end
        check({tag, "_cycles"}, n, exp_n);
        check({tag, "_stall_busy_low"}, stall_low, 0);
        check({tag, "_HI"}, HI, exp_hi);
        check({tag, "_LO"}, LO, exp_lo);
    endtask

    initial begin
        int n;
        int seen;
        reset = 1'b1; A = 32'd0; B = 32'd0; MDsel = 4'd0; start = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("reset_HI", HI, 32'd0);
        check("reset_LO", LO, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);

        run_op("mult", 4'd1, 32'hfffffffd, 32'd5, 5, 32'hffffffff, 32'hfffffff1, 1'b0);
        run_op("multu", 4'd2, 32'hffffffff, 32'hffffffff, 5, 32'hfffffffe, 32'h00000001, 1'b1);
        run_op("div", 4'd3, 32'hfffffff9, 32'd2, 10, 32'hffffffff, 32'hfffffffd, 1'b0);
        run_op("divu", 4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3, 1'b0);
        run_op("div_ovf", 4'd3, 32'h80000000, 32'hffffffff, 10, 32'd0, 32'h80000000, 1'b0);

        // mthi / mtlo, then read back through out
        A = 32'h12345678; MDsel = 4'd5; tick();
        MDsel = 4'd7; A = 32'h0; #1;
        check("mfhi_out", out, 32'h12345678);
        A = 32'h00000055; MDsel = 4'd6; tick();
        MDsel = 4'd8; #1;
        check("mflo_out", out, 32'h00000055);
        MDsel = 4'd0; #1;
        check("none_out", out, 32'd0);
        MDsel = 4'd9; #1;
        check("sel9_out", out, 32'd0);

        // divide by zero leaves HI/LO alone but still takes the full latency
        run_op("divu_zero", 4'd4, 32'd99, 32'd0, 10, 32'h12345678, 32'h00000055, 1'b0);

        // mult busy: div start and mtlo must be ignored; mflo still shows old LO
        A = 32'd3; B = 32'd4; MDsel = 4'd1; start = 1'b1; tick();
        start = 1'b0; MDsel = 4'd0;
        n = 0;
        while (busy && n < 100) begin
            case (n)
                0: begin MDsel = 4'd8; #1; check("busy_mflo_old", out, 32'h00000055); end
                1: begin MDsel = 4'd3; start = 1'b1; A = 32'd100; B = 32'd7; #1;
                         check("busy_stall", {31'd0, stall}, 32'd1); end
                2: begin MDsel = 4'd6; start = 1'b0; A = 32'h0000dead; end
                default: MDsel = 4'd0;
            endcase
            n++;
            tick();
        end
        MDsel = 4'd0; start = 1'b0;
        check("ignore_cycles", n, 5);
        check("ignore_LO", LO, 32'd12);
        check("ignore_HI", HI, 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) seen++;
            tick();
        end
        check("ignore_no_late_busy", seen, 0);
        check("ignore_LO_after", LO, 32'd12);

        // reset on the 3rd busy cycle of a divide
        A = 32'h00000abc; MDsel = 4'd5; tick();
        A = 32'd100; B = 32'd7; MDsel = 4'd3; start = 1'b1; tick();
        start = 1'b0; MDsel = 4'd0;
        tick(); tick();
        check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1; tick();
        reset = 1'b0; #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_HI", HI, 32'd0);
        check("rst_mid_LO", LO, 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy || HI != 32'd0 || LO != 32'd0) seen++;
            tick();
        end
        check("rst_no_late_write", seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
